t05_hist_ctrl: RTL and testbench

//  Sequencer for the histogram stage of the compression pipeline.
//  - On start: zeroes all histogram bins in SRAM.
//  - Then takes bytes from the SPI byte stream and does one read-modify-write (count+1) per byte on the bin at the byte's address.
//  - Ends on the EOF byte and reports the total byte count to the downstream tree builder.
//  - Sole SRAM master for the histogram region. Upstream and SRAM each use a valid/ready or req/ack handshake.

---
 rtl/t05_hist_ctrl.sv | 190 +++++++++++++++++++
 tb/tb_t05_hist_ctrl.sv | 336 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/t05_hist_ctrl.sv
// Histogram sequencer: clears all SRAM bins, then does one saturating
// read-modify-write per upstream byte until the EOF byte, reporting the byte total.
module t05_hist_ctrl #(
  parameter int unsigned ADDR_W   = 8,
  parameter int unsigned CNT_W    = 32,
  parameter logic [7:0]  EOF_CHAR = 8'h1A
) (
  input  logic              clk,
  input  logic              nrst,
  input  logic              start,
  input  logic              abort,
  input  logic              char_valid,
  input  logic [7:0]        char_data,
  output logic              char_ready,
  output logic              sram_req,
  output logic              sram_we,
  output logic [ADDR_W-1:0] sram_addr,
  output logic [CNT_W-1:0]  sram_wdata,
  input  logic [CNT_W-1:0]  sram_rdata,
  input  logic              sram_ack,
  output logic              busy,
  output logic              done,
  output logic [CNT_W-1:0]  total
);

  // Address of the last bin (NUM_BINS-1).
  localparam logic [ADDR_W-1:0] LAST_BIN = '1;

  typedef enum logic [2:0] {IDLE, CLEAR, WAIT_CHAR, RD, WR, DONE} state_e;

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   clr_addr_q, clr_addr_d;
  logic [ADDR_W-1:0]   byte_q, byte_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [CNT_W-1:0]    total_q, total_d;
  logic                abort_pend_q, abort_pend_d;
  logic                sram_req_q, sram_req_d;
  logic                sram_we_q, sram_we_d;
  logic [ADDR_W-1:0]   sram_addr_q, sram_addr_d;
  logic [CNT_W-1:0]    sram_wdata_q, sram_wdata_d;
  logic                char_ready_q, char_ready_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic                abort_now;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  assign abort_now = abort | abort_pend_q;

  // Next state; an abort inside an SRAM access waits for that access's ack.
  always_comb begin
    state_d      = state_q;
    clr_addr_d   = clr_addr_q;
    byte_d       = byte_q;
    cnt_d        = cnt_q;
    total_d      = total_q;
    abort_pend_d = abort_pend_q;
    case (state_q)
      IDLE: begin
        if (!abort && start) begin
          state_d    = CLEAR;
          clr_addr_d = '0;
          total_d    = '0;
        end
      end
      CLEAR: begin
        abort_pend_d = abort_now;
        if (sram_ack) begin
          if (abort_now) begin
            state_d      = IDLE;
            abort_pend_d = 1'b0;
          end else if (clr_addr_q == LAST_BIN) begin
            state_d = WAIT_CHAR;
          end else begin
            clr_addr_d = clr_addr_q + ADDR_W'(1);
          end
        end
      end
      WAIT_CHAR: begin
        if (abort) begin
          state_d = IDLE;
        end else if (char_valid && char_ready_q) begin
          if (char_data == EOF_CHAR) begin
            state_d = DONE;
          end else begin
            byte_d  = ADDR_W'(char_data);
            state_d = RD;
          end
        end
      end
      RD: begin
        abort_pend_d = abort_now;
        if (sram_ack) begin
          cnt_d = sram_rdata;
          if (abort_now) begin
            state_d      = IDLE;
            abort_pend_d = 1'b0;
          end else begin
            state_d = WR;
          end
        end
      end
      WR: begin
        abort_pend_d = abort_now;
        if (sram_ack) begin
          total_d = sat_inc(total_q);
          if (abort_now) begin
            state_d      = IDLE;
            abort_pend_d = 1'b0;
          end else begin
            state_d = WAIT_CHAR;
          end
        end
      end
      DONE: begin
        if (abort) begin
          state_d = IDLE;
        end else if (start) begin
          state_d    = CLEAR;
          clr_addr_d = '0;
          total_d    = '0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Outputs are registered from the next state so they are valid on state entry.
  always_comb begin
    sram_req_d   = (state_d == CLEAR) || (state_d == RD) || (state_d == WR);
    sram_we_d    = (state_d == CLEAR) || (state_d == WR);
    sram_addr_d  = '0;
    sram_wdata_d = '0;
    if (state_d == CLEAR) begin
      sram_addr_d = clr_addr_d;
    end else if ((state_d == RD) || (state_d == WR)) begin
      sram_addr_d = byte_d;
    end
    if (state_d == WR) begin
      sram_wdata_d = sat_inc(cnt_d);
    end
    char_ready_d = (state_d == WAIT_CHAR);
    busy_d       = (state_d != IDLE) && (state_d != DONE);
    done_d       = (state_d == DONE);
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state_q      <= IDLE;
      clr_addr_q   <= '0;
      byte_q       <= '0;
      cnt_q        <= '0;
      total_q      <= '0;
      abort_pend_q <= 1'b0;
      sram_req_q   <= 1'b0;
      sram_we_q    <= 1'b0;
      sram_addr_q  <= '0;
      sram_wdata_q <= '0;
      char_ready_q <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      clr_addr_q   <= clr_addr_d;
      byte_q       <= byte_d;
      cnt_q        <= cnt_d;
      total_q      <= total_d;
      abort_pend_q <= abort_pend_d;
      sram_req_q   <= sram_req_d;
      sram_we_q    <= sram_we_d;
      sram_addr_q  <= sram_addr_d;
      sram_wdata_q <= sram_wdata_d;
      char_ready_q <= char_ready_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
    end
  end

  assign char_ready = char_ready_q;
  assign sram_req   = sram_req_q;
  assign sram_we    = sram_we_q;
  assign sram_addr  = sram_addr_q;
  assign sram_wdata = sram_wdata_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign total      = total_q;

endmodule

// File: tb/tb_t05_hist_ctrl.sv
// Bench for t05_hist_ctrl: SRAM responder with random ack delay plus a
// transaction-level reference (expected access list, histogram, run phase).
module tb_t05_hist_ctrl;

  localparam logic [7:0] EOF_B = 8'h1A;
  localparam int         BOUND = 2000;

  logic        clk = 1'b0;
  logic        nrst = 1'b1;
  logic        start, abort, char_valid;
  logic [7:0]  char_data;
  logic        char_ready, sram_req, sram_we, busy, done;
  logic [7:0]  sram_addr;
  logic [31:0] sram_wdata, total;
  logic [31:0] sram_rdata = 32'h0;
  logic        sram_ack = 1'b0;

  t05_hist_ctrl dut (
    .clk(clk), .nrst(nrst), .start(start), .abort(abort),
    .char_valid(char_valid), .char_data(char_data), .char_ready(char_ready),
    .sram_req(sram_req), .sram_we(sram_we), .sram_addr(sram_addr),
    .sram_wdata(sram_wdata), .sram_rdata(sram_rdata), .sram_ack(sram_ack),
    .busy(busy), .done(done), .total(total)
  );

  always #5 clk = ~clk;

  typedef enum logic [1:0] {K_CLR, K_RD, K_WR} kind_e;
  typedef struct { kind_e kind; logic we; logic [7:0] addr; logic [31:0] wdata; } acc_t;
  typedef enum logic [1:0] {PH_IDLE, PH_RUN, PH_DONE} ph_e;

  // Reference state (owned by the checker process)
  acc_t        expq[$];
  acc_t        e_acc;
  ph_e         phase = PH_IDLE;
  logic [31:0] mem[256];
  logic [31:0] ref_hist[256];
  logic [31:0] run_total = 0;
  int          n_clr = 0;
  bit          pend = 0, in_prog = 0, ack_now, exp_ready;
  int          dly = 0;
  int          n_cmp = 0, n_err = 0;
  int          fin_ack = 0;

  // Stimulus-owned knobs and final-check requests
  int          max_dly = 0, force_dly = -1, tmo_cnt = 0, fin_req = 0;
  bit          preload_en = 0;
  int          lit_n = 0;
  int          lit_addr[4];
  logic [31:0] lit_val[4];
  bit          lit_tot_en, lit_clr_en, lit_idle, lit_done, fin_bins;
  logic [31:0] lit_total;

  function automatic logic [31:0] sat1(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Checker and SRAM responder, evaluated once per cycle on the falling edge.
  always @(negedge clk) begin
    if (!nrst) begin
      chk("rst_req", 32'(sram_req), 32'd0);
      chk("rst_we", 32'(sram_we), 32'd0);
      chk("rst_addr", 32'(sram_addr), 32'd0);
      chk("rst_wdata", sram_wdata, 32'd0);
      chk("rst_ready", 32'(char_ready), 32'd0);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_done", 32'(done), 32'd0);
      chk("rst_total", total, 32'd0);
      phase = PH_IDLE; expq.delete(); pend = 0; in_prog = 0; run_total = 0;
      sram_ack = 1'b0;
    end else begin
      exp_ready = (phase == PH_RUN) && (expq.size() == 0);
      chk("busy", 32'(busy), 32'(phase == PH_RUN));
      chk("done", 32'(done), 32'(phase == PH_DONE));
      chk("char_ready", 32'(char_ready), 32'(exp_ready));
      chk("sram_req", 32'(sram_req), 32'((phase == PH_RUN) && (expq.size() != 0)));
      chk("total", total, run_total);
      ack_now = 1'b0;
      if (sram_req) begin
        if (expq.size() != 0) begin
          chk("acc_we", 32'(sram_we), 32'(expq[0].we));
          chk("acc_addr", 32'(sram_addr), 32'(expq[0].addr));
          if (expq[0].we) chk("acc_wdata", sram_wdata, expq[0].wdata);
        end
        if (!in_prog) begin
          in_prog = 1;
          dly = (force_dly >= 0) ? force_dly : int'($urandom_range(32'(max_dly), 0));
        end
        if (dly == 0) begin ack_now = 1'b1; in_prog = 0; end
        else dly--;
      end
      sram_ack   = ack_now;
      sram_rdata = $urandom;
      if (ack_now) begin
        if (!sram_we) sram_rdata = mem[sram_addr];
        else mem[sram_addr] = sram_wdata;
        if (expq.size() != 0) begin
          e_acc = expq.pop_front();
          if (e_acc.kind == K_CLR) begin
            n_clr++;
            if (expq.size() == 0 && preload_en) begin
              mem[8'h41] = 32'hFFFF_FFFF; ref_hist[8'h41] = 32'hFFFF_FFFF;
            end
          end else if (e_acc.kind == K_WR) begin
            ref_hist[e_acc.addr] = e_acc.wdata;
            run_total = sat1(run_total);
          end
        end
        if (pend) begin phase = PH_IDLE; expq.delete(); pend = 0; end
      end
      if (abort) begin
        if (phase == PH_RUN && expq.size() != 0 && !ack_now) pend = 1;
        else begin phase = PH_IDLE; expq.delete(); pend = 0; end
      end else if (start) begin
        if (phase != PH_RUN) begin
          phase = PH_RUN; expq.delete(); run_total = 0; n_clr = 0;
          for (int i = 0; i < 256; i++) begin
            expq.push_back('{K_CLR, 1'b1, 8'(i), 32'd0});
            ref_hist[i] = 32'd0;
          end
        end
      end else if (exp_ready && char_valid) begin
        if (char_data == EOF_B) phase = PH_DONE;
        else begin
          expq.push_back('{K_RD, 1'b0, char_data, 32'd0});
          expq.push_back('{K_WR, 1'b1, char_data, sat1(ref_hist[char_data])});
        end
      end
      if (fin_req != fin_ack) begin
        if (fin_bins)
          for (int i = 0; i < 256; i++) chk("bin", mem[i], ref_hist[i]);
        for (int i = 0; i < lit_n; i++) chk("lit_bin", mem[lit_addr[i]], lit_val[i]);
        if (lit_tot_en) chk("lit_total", total, lit_total);
        if (lit_clr_en) chk("lit_clear_writes", 32'(n_clr), 32'd256);
        if (lit_idle) begin
          chk("lit_idle_busy", 32'(busy), 32'd0);
          chk("lit_idle_done", 32'(done), 32'd0);
          chk("lit_idle_req", 32'(sram_req), 32'd0);
        end
        if (lit_done) chk("lit_done", 32'(done), 32'd1);
        chk("timeouts", 32'(tmo_cnt), 32'd0);
        fin_ack = fin_req;
      end
    end
  end

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic pulse_start();
    start = 1'b1; step(); start = 1'b0;
  endtask

  task automatic pulse_abort();
    abort = 1'b1; step(); abort = 1'b0;
  endtask

  task automatic send_bytes(input logic [7:0] q[$]);
    bit got;
    foreach (q[n]) begin
      repeat ($urandom_range(2, 0)) step();
      char_valid = 1'b1; char_data = q[n]; got = 0;
      for (int k = 0; k < BOUND; k++) begin
        @(negedge clk);
        if (char_ready) begin got = 1; break; end
      end
      step(); char_valid = 1'b0;
      if (!got) begin
        $display("FAIL send_timeout: got no char_ready want char_ready=1 at %0t", $time);
        tmo_cnt++;
        return;
      end
    end
  endtask

  task automatic wait_sig(input bit for_done);
    bit got = 0;
    for (int k = 0; k < BOUND; k++) begin
      @(negedge clk);
      if ((for_done && done) || (!for_done && char_ready)) begin got = 1; break; end
    end
    step();
    if (!got) begin
      $display("FAIL wait_timeout: got no %s want it within %0d cycles", for_done ? "done" : "char_ready", BOUND);
      tmo_cnt++;
    end
  endtask

  task automatic run_stream(input logic [7:0] q[$], input bit extra_start);
    pulse_start();
    if (extra_start) begin repeat (10) step(); pulse_start(); end
    send_bytes(q);
    wait_sig(1'b1);
  endtask

  task automatic clr_lits();
    lit_n = 0; lit_tot_en = 0; lit_clr_en = 0; lit_idle = 0; lit_done = 0; fin_bins = 0;
    lit_total = 0;
  endtask

  task automatic add_lit(input int a, input logic [31:0] v);
    lit_addr[lit_n] = a; lit_val[lit_n] = v; lit_n++;
  endtask

  task automatic do_final();
    fin_req++;
    for (int k = 0; k < 10; k++) begin
      @(posedge clk);
      if (fin_ack == fin_req) break;
    end
    if (fin_ack != fin_req) begin
      $display("FAIL final_check: got no checker response want response within 10 cycles");
      tmo_cnt++;
    end
    #1 clr_lits();
  endtask

  logic [7:0] s3[$];
  logic [7:0] rq[$];
  logic [7:0] b;

  initial begin
    start = 0; abort = 0; char_valid = 0; char_data = 0;
    clr_lits();
    #2 nrst = 1'b0;
    repeat (3) @(posedge clk);
    #1 nrst = 1'b1;
    step();

    // Reference stream with immediate acks; byte presented during the clear
    s3 = '{8'h41, 8'h42, 8'h41, 8'h43, EOF_B};
    max_dly = 0;
    run_stream(s3, 1'b0);
    add_lit(65, 32'd2); add_lit(66, 32'd1); add_lit(67, 32'd1); add_lit(68, 32'd0);
    lit_tot_en = 1; lit_total = 32'd4; lit_clr_en = 1; lit_done = 1; fin_bins = 1;
    do_final();

    // Same stream, random ack delays, restarted from DONE
    max_dly = 5;
    run_stream(s3, 1'b0);
    add_lit(65, 32'd2); add_lit(66, 32'd1); add_lit(67, 32'd1);
    lit_tot_en = 1; lit_total = 32'd4; lit_clr_en = 1; lit_done = 1; fin_bins = 1;
    do_final();

    // Saturated bin stays all-ones
    max_dly = 2; preload_en = 1;
    run_stream('{8'h41, EOF_B}, 1'b0);
    preload_en = 0;
    add_lit(65, 32'hFFFF_FFFF);
    lit_tot_en = 1; lit_total = 32'd1; fin_bins = 1; lit_done = 1;
    do_final();

    // Abort during a stalled read leaves the bin untouched
    max_dly = 0;
    pulse_start();
    wait_sig(1'b0);
    force_dly = 3;
    send_bytes('{8'h42});
    pulse_abort();
    force_dly = -1;
    repeat (6) step();
    add_lit(66, 32'd0); lit_idle = 1; fin_bins = 1;
    do_final();
    run_stream('{8'h42, EOF_B}, 1'b0);
    add_lit(66, 32'd1); lit_tot_en = 1; lit_total = 32'd1; lit_clr_en = 1; fin_bins = 1;
    do_final();

    // Asynchronous reset while a read request is outstanding
    pulse_start();
    wait_sig(1'b0);
    force_dly = 5;
    send_bytes('{8'h43});
    #1 nrst = 1'b0;
    repeat (2) @(posedge clk);
    #1 nrst = 1'b1;
    force_dly = -1;
    step();
    lit_idle = 1; lit_tot_en = 1; lit_total = 32'd0; fin_bins = 1;
    do_final();

    // Random streams, one with an ignored start pulse during the clear
    for (int r = 0; r < 4; r++) begin
      max_dly = int'($urandom_range(5, 0));
      rq.delete();
      for (int n = 0; n < 15 + int'($urandom_range(15, 0)); n++) begin
        b = ($urandom_range(3, 0) == 0) ? 8'($urandom_range(255, 0)) : 8'(8'h60 + $urandom_range(3, 0));
        if (b == EOF_B) b = 8'h1B;
        rq.push_back(b);
      end
      rq.push_back(EOF_B);
      run_stream(rq, r == 1);
      lit_done = 1; lit_clr_en = 1; fin_bins = 1;
      do_final();
    end

    // Abort during the clear sweep
    max_dly = 1;
    pulse_start();
    repeat (20) step();
    pulse_abort();
    repeat (8) step();
    lit_idle = 1;
    do_final();

    // Abort while waiting for a byte
    max_dly = 0;
    pulse_start();
    wait_sig(1'b0);
    pulse_abort();
    repeat (2) step();
    lit_idle = 1; fin_bins = 1;
    do_final();

    // Empty run, then start and abort together from DONE: abort wins
    run_stream('{EOF_B}, 1'b0);
    lit_done = 1; lit_tot_en = 1; lit_total = 32'd0; fin_bins = 1;
    do_final();
    start = 1'b1; abort = 1'b1; step(); start = 1'b0; abort = 1'b0;
    repeat (3) step();
    lit_idle = 1;
    do_final();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
